// File: rtl/bram_server_pkg.sv
// Shared definitions for the BRAM port server: read latency and credit width helpers.
package bram_server_pkg;

  // BRAM read latency in cycles: 1 for the plain output, 2 with the output register enabled.
  function automatic int read_latency(input int pipelined);
    return (pipelined != 0) ? 2 : 1;
  endfunction

  // Width needed to count 0..depth inclusive (credits and FIFO occupancy).
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bram_resp_fifo.sv
// Response FIFO with a registered head. A push into an empty FIFO lands directly in the
// head register at the push edge, so the consumer sees it the following cycle and a
// simultaneous push/pop on a single entry streams without a bubble.
module bram_resp_fifo
  import bram_server_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = credit_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]       wr_ptr;
  logic [PTRW-1:0]       rd_ptr;
  logic [PTRW-1:0]       rd_ptr_next;
  logic [CW-1:0]         count;
  logic [CW-1:0]         remain;
  logic                  pop_eff;

  // Entries already stored (written at an earlier edge) that survive this edge's pop.
  always_comb begin
    pop_eff     = pop & head_valid;
    rd_ptr_next = rd_ptr + PTRW'(pop_eff);
    remain      = count - CW'(pop_eff);
  end

  // Storage array: no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the registered head; head bypasses from push_data when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTRW'(1);
      end
      rd_ptr <= rd_ptr_next;
      count  <= count + CW'(push) - CW'(pop_eff);
      if (remain != '0) begin
        head_valid <= 1'b1;
        head_data  <= mem[rd_ptr_next];
      end else if (push) begin
        head_valid <= 1'b1;
        head_data  <= push_data;
      end else begin
        head_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bram_port_server.sv
// Request/response front end for one port of a byte-enabled write-first BRAM.
// Credits bound the number of outstanding responses so the FIFO can never overflow.
// Optional feature macro: BRAM_PORT_SERVER_WRITE_ACK_EN (writes also return the merged word).
module bram_port_server
  import bram_server_pkg::*;
#(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 8,
  parameter int CHUNKSIZE  = 8,
  parameter int WE_WIDTH   = 1,
  parameter int PIPELINED  = 0,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WE_WIDTH-1:0]   req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  bram_en,
  output logic [WE_WIDTH-1:0]   bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_di,
  input  logic [DATA_WIDTH-1:0] bram_do
);

  localparam int L  = read_latency(PIPELINED);
  localparam int CW = credit_width(DEPTH);

  generate
    if (DATA_WIDTH != WE_WIDTH * CHUNKSIZE) begin : g_bad_width
      $error("DATA_WIDTH must equal WE_WIDTH*CHUNKSIZE");
    end
    if ((DEPTH < L + 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("DEPTH must be a power of two and at least read latency + 1");
    end
  endgenerate

  typedef struct packed {
    logic [WE_WIDTH-1:0]   we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  req_t          req;
  logic [CW-1:0] credits;
  logic [L-1:0]  inflight;
  logic [L:0]    shift_in;
  logic          rsp_gen;
  logic          push;
  logic          pop;

  assign req = '{we: req_we, addr: req_addr, data: req_data};

  // Strobes pass straight through; acceptance only depends on credit availability.
  assign req_ready = rst_n & (credits != '0);
  assign bram_en   = req_valid & req_ready;
  assign bram_we   = req.we & {WE_WIDTH{bram_en}};
  assign bram_addr = req.addr;
  assign bram_di   = req.data;

`ifdef BRAM_PORT_SERVER_WRITE_ACK_EN
  assign rsp_gen = bram_en;
`else
  assign rsp_gen = bram_en & ~(|req.we);
`endif

  assign shift_in = {inflight, rsp_gen};
  assign push     = inflight[L-1];
  assign pop      = rsp_valid & rsp_ready;

  // Credit counter: take one per response-generating accept, return one per pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= CW'(DEPTH);
    end else begin
      credits <= credits - CW'(rsp_gen) + CW'(pop);
    end
  end

  // Latency shift register: bit L-1 marks the edge at which bram_do holds the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      inflight <= shift_in[L-1:0];
    end
  end

  bram_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (bram_do),
    .pop        (pop),
    .head_valid (rsp_valid),
    .head_data  (rsp_data)
  );

endmodule

// File: tb/tb_bram_port_server.sv
// Bench for bram_port_server: two instances (read latency 1 and 2), each with a BRAM model,
// a shadow-memory reference model, an expected-response queue and an independent monitor.
module tb_bram_port_server;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int WEW   = 2;
  localparam int CS    = 8;
  localparam int DEPTH = 4;

`ifdef BRAM_PORT_SERVER_WRITE_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done_flag [2];
  logic clk = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int lat,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL [L=%0d] %s: got %h, expected %h", lat, name, act, exp);
    end
  endtask

  // Byte-lane merge of a write into an existing word.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [WEW-1:0] we,
                                          input logic [DW-1:0] di);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < WEW; b++) begin
      if (we[b]) r[b*CS +: CS] = di[b*CS +: CS];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 5) return 16'h00A5;
    if (i == 3) return 16'hFFFF;
    return DW'((i * 32'h1111) ^ 32'h0F0F);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int LAT = gi + 1;

      logic           rst_n;
      logic           req_valid;
      logic           req_ready;
      logic [WEW-1:0] req_we;
      logic [AW-1:0]  req_addr;
      logic [DW-1:0]  req_data;
      logic           rsp_valid;
      logic           rsp_ready;
      logic [DW-1:0]  rsp_data;
      logic           bram_en;
      logic [WEW-1:0] bram_we;
      logic [AW-1:0]  bram_addr;
      logic [DW-1:0]  bram_di;
      logic [DW-1:0]  bram_do;

      logic [DW-1:0]  ram [16];
      logic [DW-1:0]  do1;
      logic [DW-1:0]  do2;
      logic           load;

      logic [DW-1:0]  shadow [16];
      logic [DW-1:0]  exp_q [$];
      logic [DW-1:0]  last_rsp;
      int             rsp_mode;
      int             pops;

      bram_port_server #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CHUNKSIZE  (CS),
        .WE_WIDTH   (WEW),
        .PIPELINED  (gi),
        .DEPTH      (DEPTH)
      ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_di   (bram_di),
        .bram_do   (bram_do)
      );

      // Write-first byte-enabled BRAM port with 1 or 2 cycles of read latency.
      always @(posedge clk) begin
        if (load) begin
          for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
        end else if (bram_en) begin
          ram[bram_addr] <= merge(ram[bram_addr], bram_we, bram_di);
          do1            <= merge(ram[bram_addr], bram_we, bram_di);
        end
        do2 <= do1;
      end
      assign bram_do = (LAT == 1) ? do1 : do2;

      // One request slot: drive at negedge, decide acceptance, update the reference model.
      task automatic cycle_req(input bit v, input logic [WEW-1:0] we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, output bit acc);
        logic [DW-1:0] merged;
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_data  = d;
        #1;
        if (rst_n) begin
          chk(req_ready == (exp_q.size() < DEPTH), "req_ready vs credits", LAT,
              32'(req_ready), 32'(exp_q.size() < DEPTH));
        end
        acc = v && req_ready;
        chk(bram_en == acc, "bram_en", LAT, 32'(bram_en), 32'(acc));
        if (acc) begin
          chk(bram_we == we, "bram_we", LAT, 32'(bram_we), 32'(we));
          merged = merge(shadow[a], we, d);
          if (we != '0) shadow[a] = merged;
          if (we == '0) exp_q.push_back(shadow[a]);
          else if (WR_ACK) exp_q.push_back(merged);
        end
      endtask

      // Monitor: drives rsp_ready per mode, pops and compares whenever a response is taken.
      initial begin : monitor
        bit            held;
        logic [DW-1:0] held_data;
        logic [DW-1:0] e;
        held      = 1'b0;
        held_data = '0;
        rsp_ready = 1'b0;
        forever begin
          @(negedge clk);
          case (rsp_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'($urandom_range(0, 1));
          endcase
          #2;
          if (rst_n && rsp_valid) begin
            if (held) chk(rsp_data == held_data, "rsp_data stable while stalled", LAT,
                          32'(rsp_data), 32'(held_data));
            if (rsp_ready) begin
              held = 1'b0;
              if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected response", LAT, 32'(rsp_data), 32'h0);
              end else begin
                e = exp_q.pop_front();
                chk(rsp_data == e, "rsp_data", LAT, 32'(rsp_data), 32'(e));
                $display("[L=%0d] rsp %0d data=%h expected=%h", LAT, pops, rsp_data, e);
                last_rsp = rsp_data;
                pops++;
              end
            end else begin
              held      = 1'b1;
              held_data = rsp_data;
            end
          end else begin
            held = 1'b0;
          end
        end
      end

      // Directed scenarios followed by a long randomized run.
      initial begin : stimulus
        bit acc;
        int k, f, nv, lastv, nacc;
        logic [WEW-1:0] rwe;
        rsp_mode  = 1;
        pops      = 0;
        last_rsp  = '0;
        rst_n     = 1'b0;
        load      = 1'b1;
        req_valid = 1'b1;
        req_we    = '0;
        req_addr  = '0;
        req_data  = '0;
        for (int i = 0; i < 16; i++) shadow[i] = init_val(i);

        // Reset state, with a request offered to prove it is not accepted.
        @(negedge clk);
        #1;
        chk(rsp_valid == 1'b0, "reset rsp_valid", LAT, 32'(rsp_valid), 32'h0);
        chk(req_ready == 1'b0, "reset req_ready", LAT, 32'(req_ready), 32'h0);
        chk(bram_en == 1'b0, "reset bram_en", LAT, 32'(bram_en), 32'h0);
        chk(bram_we == '0, "reset bram_we", LAT, 32'(bram_we), 32'h0);
        chk(rsp_data == '0, "reset rsp_data", LAT, 32'(rsp_data), 32'h0);
        @(negedge clk);
        load      = 1'b0;
        req_valid = 1'b0;
        rst_n     = 1'b1;
        #1;
        chk(req_ready == 1'b1, "req_ready after reset", LAT, 32'(req_ready), 32'h1);

        // Single read of address 5 and its latency.
        cycle_req(1'b1, '0, 4'd5, '0, acc);
        chk(acc, "single read accepted", LAT, 32'(acc), 32'h1);
        k = 0;
        do begin
          cycle_req(1'b0, '0, '0, '0, acc);
          k++;
        end while (!rsp_valid && k < 10);
        chk(k == LAT + 1, "first read latency", LAT, 32'(k), 32'(LAT + 1));
        chk(rsp_data == 16'h00A5, "read addr 5", LAT, 32'(rsp_data), 32'h00A5);
        repeat (3) cycle_req(1'b0, '0, '0, '0, acc);

        // Eight back-to-back reads with the consumer always ready.
        f = -1; nv = 0; lastv = -1;
        for (int c = 0; c < 20; c++) begin
          cycle_req(c < 8, '0, AW'(c), '0, acc);
          if (c < 8) chk(acc, "back-to-back accept", LAT, 32'(acc), 32'h1);
          if (rsp_valid) begin
            if (f < 0) f = c;
            nv++;
            lastv = c;
          end
        end
        chk(f == LAT + 1, "b2b first latency", LAT, 32'(f), 32'(LAT + 1));
        chk(nv == 8, "b2b response count", LAT, 32'(nv), 32'h8);
        chk(lastv - f == 7, "b2b no gaps", LAT, 32'(lastv - f), 32'h7);

        // Consumer stalled: only DEPTH reads get in, then resume as responses drain.
        rsp_mode = 0;
        cycle_req(1'b0, '0, '0, '0, acc);
        nacc = 0;
        for (int c = 0; c < 12; c++) begin
          cycle_req(nacc < 6, '0, AW'(8 + nacc), '0, acc);
          if (acc) nacc++;
        end
        chk(nacc == DEPTH, "accepted while stalled", LAT, 32'(nacc), 32'(DEPTH));
        chk(req_ready == 1'b0, "req_ready when out of credits", LAT, 32'(req_ready), 32'h0);
        rsp_mode = 1;
        for (int c = 0; c < 30 && nacc < 6; c++) begin
          cycle_req(1'b1, '0, AW'(8 + nacc), '0, acc);
          if (acc) nacc++;
        end
        chk(nacc == 6, "all stalled reads accepted", LAT, 32'(nacc), 32'h6);
        repeat (10) cycle_req(1'b0, '0, '0, '0, acc);

        // Partial write over 0xFFFF, then read back the merged word.
        cycle_req(1'b1, 2'b01, 4'd3, 16'h1234, acc);
        cycle_req(1'b1, '0, 4'd3, '0, acc);
        repeat (8) cycle_req(1'b0, '0, '0, '0, acc);
        chk(last_rsp == 16'hFF34, "write-merge readback", LAT, 32'(last_rsp), 32'hFF34);

        // Reset with reads both in flight and queued.
        rsp_mode = 0;
        cycle_req(1'b0, '0, '0, '0, acc);
        for (int c = 0; c < 4; c++) cycle_req(1'b1, '0, AW'(c), '0, acc);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk(rsp_valid == 1'b0, "rsp_valid drops in reset", LAT, 32'(rsp_valid), 32'h0);
        chk(req_ready == 1'b0, "req_ready in reset", LAT, 32'(req_ready), 32'h0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        rsp_mode = 1;
        for (int c = 0; c < 8; c++) begin
          cycle_req(1'b0, '0, '0, '0, acc);
          chk(rsp_valid == 1'b0, "no stale push after reset", LAT, 32'(rsp_valid), 32'h0);
        end

        // Randomized traffic with random consumer stalls.
        rsp_mode = 2;
        for (int c = 0; c < 10000; c++) begin
          rwe = ($urandom_range(0, 2) == 0) ? WEW'($urandom_range(1, 3)) : '0;
          cycle_req($urandom_range(0, 3) != 0, rwe, AW'($urandom), DW'($urandom), acc);
        end
        rsp_mode = 1;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) cycle_req(1'b0, '0, '0, '0, acc);
        chk(exp_q.size() == 0, "all responses drained", LAT, 32'(exp_q.size()), 32'h0);
        done_flag[gi] = 1'b1;
      end
    end
  endgenerate

  initial begin : finisher
    int c;
    done_flag[0] = 1'b0;
    done_flag[1] = 1'b0;
    c = 0;
    while (!(done_flag[0] && done_flag[1]) && c < 60000) begin
      @(negedge clk);
      c++;
    end
    chk(done_flag[0] && done_flag[1], "test completed in time", 0, 32'(c), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
